cache_nway_d: RTL and testbench

CACHE_NWAY_D -- requirements
Module: cache_nway_d

---
 rtl/cache_nway_d_if.sv | 32 +++
 rtl/cache_nway_d.sv | 177 +++++++++++++++++
 tb/tb_cache_nway_d.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_d_if.sv
// CPU-side and physical-memory-side signal bundle for the N-way write-back cache.
interface cache_nway_d_if;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // master: the CPU plus physical memory around the cache
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  // slave: the cache itself
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_nway_d.sv
// N-way set-associative write-back cache with 128-bit lines and tree pseudo-LRU.
// Hits complete in the same cycle; misses write back a dirty victim, then fill.
module cache_nway_d #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned LINES = 8
) (
  input logic           clk,
  input logic           reset,
  cache_nway_d_if.slave bus
);

  localparam int unsigned WW = $clog2(WAYS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 12 - IW;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [127:0]     data_q  [WAYS][LINES];
  logic [TW-1:0]    tag_q   [WAYS][LINES];
  logic [LINES-1:0] valid_q [WAYS];
  logic [LINES-1:0] dirty_q [WAYS];
  // Tree nodes live at heap positions 1..WAYS-1; bit 0 is a spare.
  logic [WAYS-1:0]  plru_q  [LINES];

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] victim_q;

  logic [2:0]    off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag_in;
  logic          req;
  logic          unused_addr_bit;

  assign off             = bus.mem_address[3:1];
  assign idx             = bus.mem_address[4 +: IW];
  assign tag_in          = bus.mem_address[15 -: TW];
  assign req             = bus.mem_read | bus.mem_write;
  assign unused_addr_bit = bus.mem_address[0];

  logic          hit;
  logic [WW-1:0] hit_way;
  logic          has_inv;
  logic [WW-1:0] inv_way;

  // Tag lookup and lowest-numbered invalid way in the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!has_inv && !valid_q[w][idx]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  logic [WAYS-1:0] plru_cur, plru_upd;
  logic [WW-1:0]   lru_way, victim_c;
  int unsigned     node, path;

  // A node bit of 1 means the least-recently-used half is on the right
  always_comb begin
    plru_cur = plru_q[idx];
    node     = 32'd1;
    for (int unsigned l = 0; l < WW; l++) begin
      node = 32'(2 * node) + 32'(plru_cur[WW'(node)]);
    end
    lru_way  = WW'(node);
    victim_c = has_inv ? inv_way : lru_way;

    plru_upd = plru_cur;
    path     = WAYS + 32'(hit_way);
    for (int unsigned l = 0; l < WW; l++) begin
      plru_upd[WW'(path >> (WW - l))] = ~1'(path >> (WW - 1 - l));
    end
  end

  logic [127:0] hit_line, merged_line;
  logic [15:0]  old_word, new_word;

  // Byte-merge of write data into the addressed word of the hit way
  always_comb begin
    hit_line    = data_q[hit_way][idx];
    old_word    = hit_line[{off, 4'b0000} +: 16];
    new_word[7:0]  = bus.mem_byte_enable[0] ? bus.mem_wdata[7:0]  : old_word[7:0];
    new_word[15:8] = bus.mem_byte_enable[1] ? bus.mem_wdata[15:8] : old_word[15:8];
    merged_line = hit_line;
    merged_line[{off, 4'b0000} +: 16] = new_word;
  end

  logic hit_en, wb_done, fill_en;
  assign hit_en  = (state_q == IDLE) && req && hit;
  assign wb_done = (state_q == WRITEBACK) && bus.pmem_resp;
  assign fill_en = (state_q == ALLOCATE) && bus.pmem_resp;

  assign bus.mem_rdata  = old_word;
  assign bus.pmem_wdata = data_q[victim_q][idx];

  // Next-state and handshake outputs
  always_comb begin
    state_d          = state_q;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = {bus.mem_address[15:4], 4'b0000};
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            bus.mem_resp = 1'b1;
          end else if (valid_q[victim_c][idx] && dirty_q[victim_c][idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[victim_q][idx], idx, 4'b0000};
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, victim latch, valid/dirty/PLRU bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int w = 0; w < int'(WAYS); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < int'(LINES); s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d != IDLE)) victim_q <= victim_c;
      if (hit_en) begin
        plru_q[idx] <= plru_upd;
        if (bus.mem_write) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (wb_done) dirty_q[victim_q][idx] <= 1'b0;
      if (fill_en) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  // Line data and tags carry no reset value; reset only blocks updates
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (hit_en && bus.mem_write) data_q[hit_way][idx] <= merged_line;
      if (fill_en) begin
        data_q[victim_q][idx] <= bus.pmem_rdata;
        tag_q[victim_q][idx]  <= tag_in;
      end
    end
  end

endmodule

// File: tb/tb_cache_nway_d.sv
// Randomized self-checking bench for cache_nway_d against a set/way/PLRU model
// and a flat memory image of what every address must read back as.
module tb_cache_nway_d;
  parameter int unsigned WAYS  = 4;
  parameter int unsigned LINES = 8;

  localparam int IW   = $clog2(LINES);
  localparam int MAXC = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_nway_d_if bus ();

  cache_nway_d #(.WAYS(WAYS), .LINES(LINES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] mem_img [int];
  logic [127:0] truth   [int];
  bit           m_valid [WAYS][LINES];
  bit           m_dirty [WAYS][LINES];
  int           m_tag   [WAYS][LINES];
  bit           m_plru  [LINES][WAYS];

  logic [15:0] first_pa;
  logic [15:0] last_rdata;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input int la);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = 16'((la << 4) + i) ^ 16'hA5A5;
    return l;
  endfunction

  function automatic logic [127:0] get_mem(input int la);
    return mem_img.exists(la) ? mem_img[la] : init_line(la);
  endfunction

  function automatic logic [127:0] get_truth(input int la);
    return truth.exists(la) ? truth[la] : init_line(la);
  endfunction

  // Tree PLRU as nested halving of the way range; a set bit points at the right half
  function automatic int plru_victim(input int s);
    int lo = 0, hi = int'(WAYS), node = 1, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_plru[s][node]) begin lo = mid; node = 2 * node + 1; end
      else begin hi = mid; node = 2 * node; end
    end
    return lo;
  endfunction

  task automatic touch(input int s, input int w);
    int lo = 0, hi = int'(WAYS), node = 1, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_plru[s][node] = 1'b1; hi = mid; node = 2 * node; end
      else begin m_plru[s][node] = 1'b0; lo = mid; node = 2 * node + 1; end
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < int'(WAYS); w++)
      for (int s = 0; s < int'(LINES); s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
        m_plru[s][w]  = 1'b0;
      end
    truth = mem_img;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_idle();
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    chk("idle_resp", 128'(bus.mem_resp), 128'(0));
    chk("idle_pmem", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));
  endtask

  function automatic logic [15:0] addr_of(input int tg, input int s, input int off);
    return 16'((tg << (4 + IW)) | (s << 4) | (off << 1));
  endfunction

  // One CPU request; plays physical memory and checks every cycle until mem_resp
  task automatic do_access(input bit wr, input bit both, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [1:0] be);
    int s, tg, off, h, v, d1, d2, exp_lat, wb_la, la, wait_left, c, w;
    bit hit, wb, seen, saw_wb, done, got_pa;
    logic [127:0] line;
    logic [15:0]  word;
    la  = int'(addr) >> 4;
    s   = la % int'(LINES);
    tg  = int'(addr) >> (4 + IW);
    off = (int'(addr) >> 1) & 7;
    hit = 1'b0; h = 0; v = -1;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (m_valid[i][s] && m_tag[i][s] == tg) begin hit = 1'b1; h = i; end
      if (!m_valid[i][s] && v < 0) v = i;
    end
    if (v < 0) v = plru_victim(s);
    wb      = !hit && m_valid[v][s] && m_dirty[v][s];
    wb_la   = (m_tag[v][s] << IW) | s;
    d1      = int'($urandom_range(0, 3));
    d2      = int'($urandom_range(0, 3));
    exp_lat = hit ? 0 : 1 + (wb ? d1 + 1 : 0) + d2 + 1;

    @(negedge clk);
    bus.mem_read        = !wr || both;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
    seen = 1'b0; saw_wb = 1'b0; done = 1'b0; got_pa = 1'b0;
    wait_left = 0; c = 0;
    first_pa = '0;
    while (!done && c < MAXC) begin
      #1;
      chk("pmem_excl", 128'(bus.pmem_read && bus.pmem_write), 128'(0));
      if (bus.mem_resp) begin
        done = 1'b1;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (!seen) begin
          seen = 1'b1;
          if (!got_pa) begin first_pa = bus.pmem_address; got_pa = 1'b1; end
          if (bus.pmem_write) begin
            saw_wb = 1'b1;
            chk("wb_addr", 128'(bus.pmem_address), 128'(16'(wb_la << 4)));
            chk("wb_data", bus.pmem_wdata, get_truth(wb_la));
            wait_left = d1;
          end else begin
            chk("fill_addr", 128'(bus.pmem_address), 128'(16'(la << 4)));
            wait_left = d2;
          end
        end
        if (wait_left == 0) begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) mem_img[int'(bus.pmem_address) >> 4] = bus.pmem_wdata;
          else bus.pmem_rdata = get_mem(int'(bus.pmem_address) >> 4);
          seen = 1'b0;
        end else begin
          wait_left--;
        end
      end
      if (!done) begin
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        c++;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: no mem_resp within %0d cycles for addr %h", MAXC, addr);
    end else begin
      last_rdata = bus.mem_rdata;
      chk("latency", 128'(c), 128'(exp_lat));
      chk("wb_taken", 128'(saw_wb), 128'(wb));
      line = get_truth(la);
      if (!wr) chk("rdata", 128'(bus.mem_rdata), 128'(line[off*16 +: 16]));
      w = hit ? h : v;
      if (!hit) begin
        m_valid[v][s] = 1'b1;
        m_tag[v][s]   = tg;
        m_dirty[v][s] = 1'b0;
      end
      touch(s, w);
      if (wr) begin
        m_dirty[w][s] = 1'b1;
        word = line[off*16 +: 16];
        if (be[0]) word[7:0]  = wd[7:0];
        if (be[1]) word[15:8] = wd[15:8];
        line[off*16 +: 16] = word;
        truth[la] = line;
      end
    end
  endtask

  initial begin
    reset               = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b11;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;

    // Reset state, cold read fill, byte-masked write merge
    do_reset();
    #1;
    chk("rst_resp", 128'(bus.mem_resp), 128'(0));
    chk("rst_pread", 128'(bus.pmem_read), 128'(0));
    chk("rst_pwrite", 128'(bus.pmem_write), 128'(0));
    do_access(1'b0, 1'b0, 16'h1234, 16'h0, 2'b11);
    chk("cold_pa", 128'(first_pa), 128'(16'h1230));
    chk("cold_rdata", 128'(last_rdata), 128'(16'hB797));
    do_access(1'b1, 1'b0, 16'h1234, 16'h1111, 2'b11);
    do_access(1'b1, 1'b0, 16'h1234, 16'hBEEF, 2'b10);
    do_access(1'b0, 1'b0, 16'h1234, 16'h0, 2'b11);
    chk("merge_rdata", 128'(last_rdata), 128'(16'hBE11));
    do_idle();

    // Fill set 0 dirty, re-hit way 0, then miss: PLRU victim is way WAYS/2
    do_reset();
    for (int k = 0; k < int'(WAYS); k++)
      do_access(1'b1, 1'b0, addr_of(16 + k, 0, k % 8), 16'($urandom), 2'b11);
    do_access(1'b0, 1'b0, addr_of(16, 0, 1), 16'h0, 2'b11);
    do_access(1'b1, 1'b0, addr_of(48, 0, 0), 16'h5A5A, 2'b11);
    chk("plru_victim_pa", 128'(first_pa), 128'(16'((16 + int'(WAYS) / 2) << (4 + IW))));

    // WAYS+1 distinct tags with no extra hits: way 0 written back first
    do_reset();
    for (int k = 0; k < int'(WAYS); k++)
      do_access(1'b1, 1'b0, addr_of(16 + k, 0, 2), 16'($urandom), 2'b01);
    do_access(1'b1, 1'b0, addr_of(48, 0, 3), 16'h1357, 2'b11);
    chk("evict_way0_pa", 128'(first_pa), 128'(16'(16 << (4 + IW))));

    // Reset in the middle of ALLOCATE, then a stale pmem_resp
    do_reset();
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b0;
    bus.mem_address = 16'h0450;
    #1;
    chk("abort_miss_resp", 128'(bus.mem_resp), 128'(0));
    @(negedge clk);
    #1;
    chk("abort_in_alloc", 128'(bus.pmem_read), 128'(1));
    reset        = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_pread", 128'(bus.pmem_read), 128'(0));
    chk("abort_pwrite", 128'(bus.pmem_write), 128'(0));
    chk("abort_resp", 128'(bus.mem_resp), 128'(0));
    bus.pmem_rdata = '1;
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    model_reset();
    do_access(1'b0, 1'b0, 16'h0450, 16'h0, 2'b11);
    chk("abort_refill_pa", 128'(first_pa), 128'(16'h0450));
    chk("abort_refill_rdata", 128'(last_rdata), 128'(16'hA1F5));

    // Random traffic over a few sets with a small tag pool to force conflicts
    for (int n = 0; n < 400; n++) begin
      int tg, s, off, kind;
      logic [1:0] be;
      tg   = int'($urandom_range(0, WAYS + 2));
      s    = int'($urandom_range(0, (LINES > 4) ? 3 : LINES - 1));
      off  = int'($urandom_range(0, 7));
      kind = int'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       be = 2'b01;
        1:       be = 2'b10;
        default: be = 2'b11;
      endcase
      if (kind == 0) do_idle();
      else do_access(kind >= 5, kind == 7, addr_of(tg, s, off), 16'($urandom), be);
    end
    do_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
